dio24_reset_req: RTL and testbench

- Conditions the raw reset sources before they reach the dio24 reset block, in the clock_fast domain.
- Glitch-filters the asynchronous PLL lock indicator so that short dropouts cannot trigger a full reset.
- Stretches single-cycle software reset requests to a guaranteed minimum width.
- Closes a handshake on the reset_n_fast feedback, reporting completion and blocking overlapping software resets.

---
 rtl/dio24_reset_req.sv | 150 +++++++++++++++
 tb/tb_dio24_reset_req.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dio24_reset_req.sv
// Conditions raw reset sources for the dio24 reset block in the clock_fast domain:
// PLL lock glitch filter, software reset stretcher and completion handshake.
module dio24_reset_req #(
  parameter int LOCK_FILTER     = 16,
  parameter int UNLOCK_FILTER   = 4,
  parameter int SW_RESET_CYCLES = 8,
  parameter int SYNC            = 2
) (
  input  logic clock_fast,
  input  logic reset_n,
  input  logic pll_locked_in,
  input  logic sw_reset_req,
  input  logic reset_n_fast_in,
  input  logic lock_lost_clr,
  output logic reset_sw,
  output logic PLL_locked,
  output logic sw_reset_busy,
  output logic sw_reset_done,
  output logic lock_lost
);

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) <= v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int MAXLU = (LOCK_FILTER > UNLOCK_FILTER) ? LOCK_FILTER : UNLOCK_FILTER;
  localparam int MAXV  = (MAXLU > SW_RESET_CYCLES) ? MAXLU : SW_RESET_CYCLES;
  localparam int CW    = clogb2(MAXV);

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} sw_state_t;

  logic [SYNC-1:0] lk_sync;
  logic            lk_s;
  logic [CW-1:0]   lk_cnt;

  sw_state_t       state, state_n;
  logic [CW-1:0]   sw_cnt, sw_cnt_n;
  logic            seen_low, seen_low_n;
  logic            pending, pending_n;
  logic            req_d;
  logic            reset_sw_n, busy_n, done_n;

  assign lk_s = lk_sync[SYNC-1];

  // Lock synchronizer and dual-threshold filter
  always_ff @(posedge clock_fast) begin
    if (!reset_n) begin
      lk_sync    <= '0;
      lk_cnt     <= '0;
      PLL_locked <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      lk_sync <= {lk_sync[SYNC-2:0], pll_locked_in};
      if (lock_lost_clr) lock_lost <= 1'b0;
      if (!PLL_locked) begin
        if (!lk_s) begin
          lk_cnt <= '0;
        end else if (lk_cnt == CW'(LOCK_FILTER - 1)) begin
          PLL_locked <= 1'b1;
          lk_cnt     <= '0;
        end else begin
          lk_cnt <= sat_inc(lk_cnt);
        end
      end else begin
        if (lk_s) begin
          lk_cnt <= '0;
        end else if (lk_cnt == CW'(UNLOCK_FILTER - 1)) begin
          PLL_locked <= 1'b0;
          lock_lost  <= 1'b1;
          lk_cnt     <= '0;
        end else begin
          lk_cnt <= sat_inc(lk_cnt);
        end
      end
    end
  end

  // Software reset state register; outputs are registered alongside state
  always_ff @(posedge clock_fast) begin
    if (!reset_n) begin
      state         <= IDLE;
      sw_cnt        <= '0;
      seen_low      <= 1'b0;
      pending       <= 1'b0;
      req_d         <= 1'b0;
      reset_sw      <= 1'b0;
      sw_reset_busy <= 1'b0;
      sw_reset_done <= 1'b0;
    end else begin
      state         <= state_n;
      sw_cnt        <= sw_cnt_n;
      seen_low      <= seen_low_n;
      pending       <= pending_n;
      req_d         <= sw_reset_req;
      reset_sw      <= reset_sw_n;
      sw_reset_busy <= busy_n;
      sw_reset_done <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    sw_cnt_n   = sw_cnt;
    seen_low_n = seen_low;
    pending_n  = pending;
    reset_sw_n = reset_sw;
    busy_n     = sw_reset_busy;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (sw_reset_req || pending) begin
          state_n    = ASSERT;
          reset_sw_n = 1'b1;
          busy_n     = 1'b1;
          sw_cnt_n   = '0;
          seen_low_n = 1'b0;
          pending_n  = 1'b0;
        end
      end
      ASSERT: begin
        // Release needs minimum width, request dropped and downstream acknowledge
        if (sw_cnt != CW'(SW_RESET_CYCLES - 1)) sw_cnt_n = sat_inc(sw_cnt);
        if (!reset_n_fast_in) seen_low_n = 1'b1;
        if ((sw_cnt == CW'(SW_RESET_CYCLES - 1)) && !sw_reset_req && seen_low) begin
          state_n    = RELEASE;
          reset_sw_n = 1'b0;
        end
      end
      RELEASE: begin
        reset_sw_n = 1'b0;
        if (sw_reset_req && !req_d) pending_n = 1'b1;
        if (reset_n_fast_in) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dio24_reset_req.sv
// Directed bench for dio24_reset_req: table-driven lock filter vectors plus
// cycle-accurate software reset sequences against a simple downstream ack model.
module tb_dio24_reset_req;

  logic clock_fast = 1'b0;
  always #5 clock_fast = ~clock_fast;

  logic reset_n, pll_locked_in, sw_reset_req, reset_n_fast_in, lock_lost_clr;
  logic reset_sw, PLL_locked, sw_reset_busy, sw_reset_done, lock_lost;

  int n_chk  = 0;
  int n_pass = 0;

  dio24_reset_req dut (
    .clock_fast      (clock_fast),
    .reset_n         (reset_n),
    .pll_locked_in   (pll_locked_in),
    .sw_reset_req    (sw_reset_req),
    .reset_n_fast_in (reset_n_fast_in),
    .lock_lost_clr   (lock_lost_clr),
    .reset_sw        (reset_sw),
    .PLL_locked      (PLL_locked),
    .sw_reset_busy   (sw_reset_busy),
    .sw_reset_done   (sw_reset_done),
    .lock_lost       (lock_lost)
  );

  typedef struct {
    logic pll;
    logic clr;
    int   cyc;
    logic e_lk;
    logic e_lost;
  } lvec_t;

  lvec_t lv[12];

  bit   req_pat[300];
  bit   rst_pat[300];
  logic o_sw[300];
  logic o_busy[300];
  logic o_lk[300];

  int n_sw_hi, n_busy_hi, n_done, n_rise, done_t1, done_t2, rise_t2, done_wide;

  task automatic tick();
    @(posedge clock_fast);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic clr_pats();
    for (int t = 0; t < 300; t++) begin
      req_pat[t] = 1'b0;
      rst_pat[t] = 1'b0;
    end
  endtask

  // Downstream model: pulls reset_n_fast_in low for len ticks, dly ticks after each reset_sw rise.
  task automatic sw_run(input int ncyc, input int dly, input int len);
    int   rise_t;
    logic prev_sw, prev_done;
    rise_t = -1; prev_sw = 1'b0; prev_done = 1'b0;
    n_sw_hi = 0; n_busy_hi = 0; n_done = 0; n_rise = 0;
    done_t1 = -1; done_t2 = -1; rise_t2 = -1; done_wide = 0;
    for (int t = 0; t < ncyc; t++) begin
      o_sw[t]   = reset_sw;
      o_busy[t] = sw_reset_busy;
      o_lk[t]   = PLL_locked;
      if (reset_sw) n_sw_hi++;
      if (sw_reset_busy) n_busy_hi++;
      if (reset_sw && !prev_sw) begin
        rise_t = t;
        n_rise++;
        if (n_rise == 2) rise_t2 = t;
      end
      if (sw_reset_done) begin
        n_done++;
        if (prev_done) done_wide++;
        if (n_done == 1) done_t1 = t;
        if (n_done == 2) done_t2 = t;
      end
      prev_sw   = reset_sw;
      prev_done = sw_reset_done;
      reset_n         = !rst_pat[t];
      sw_reset_req    = req_pat[t];
      reset_n_fast_in = !(rise_t >= 0 && t >= rise_t + dly && t < rise_t + dly + len);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    reset_n = 1'b0; pll_locked_in = 1'b0; sw_reset_req = 1'b0;
    reset_n_fast_in = 1'b1; lock_lost_clr = 1'b0;
    repeat (5) tick();
    chk("rst.reset_sw", reset_sw, 0);
    chk("rst.PLL_locked", PLL_locked, 0);
    chk("rst.busy", sw_reset_busy, 0);
    chk("rst.done", sw_reset_done, 0);
    chk("rst.lock_lost", lock_lost, 0);

    // Power-up lock latency
    reset_n = 1'b1;
    repeat (5) tick();
    chk("pre_lock.PLL_locked", PLL_locked, 0);
    pll_locked_in = 1'b1;
    lat = 41;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (PLL_locked) begin
        lat = i;
        break;
      end
    end
    chk_rng("lock_latency", lat, 17, 19);
    chk("powerup.lock_lost", lock_lost, 0);

    lv[0]  = '{1'b1, 1'b0,  5, 1'b1, 1'b0};
    lv[1]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0};
    lv[2]  = '{1'b1, 1'b0, 10, 1'b1, 1'b0};
    lv[3]  = '{1'b0, 1'b0,  5, 1'b1, 1'b0};
    lv[4]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1};
    lv[5]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0};
    lv[6]  = '{1'b0, 1'b0,  4, 1'b0, 1'b0};
    lv[7]  = '{1'b1, 1'b0, 17, 1'b0, 1'b0};
    lv[8]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0};
    lv[9]  = '{1'b0, 1'b1,  6, 1'b0, 1'b1};
    lv[10] = '{1'b0, 1'b1,  1, 1'b0, 1'b0};
    lv[11] = '{1'b1, 1'b0, 20, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      pll_locked_in = lv[i].pll;
      lock_lost_clr = lv[i].clr;
      repeat (lv[i].cyc) tick();
      chk($sformatf("lock[%0d].PLL_locked", i), PLL_locked, lv[i].e_lk);
      chk($sformatf("lock[%0d].lock_lost", i), lock_lost, lv[i].e_lost);
    end
    lock_lost_clr = 1'b0;

    // Single-cycle request, early acknowledge
    clr_pats(); req_pat[0] = 1'b1;
    sw_run(40, 3, 20);
    chk("pulse.sw_width", n_sw_hi, 8);
    chk("pulse.n_done", n_done, 1);
    chk("pulse.done_t", done_t1, 25);
    chk("pulse.done_wide", done_wide, 0);
    chk("pulse.busy_width", n_busy_hi, 24);
    chk("pulse.busy_at_done", o_busy[25], 0);

    // Held request
    clr_pats();
    for (int t = 0; t < 20; t++) req_pat[t] = 1'b1;
    sw_run(50, 3, 25);
    chk("held.sw_width", n_sw_hi, 20);
    chk("held.n_done", n_done, 1);
    chk("held.done_t", done_t1, 30);

    // Late acknowledge holds reset_sw
    clr_pats(); req_pat[0] = 1'b1;
    sw_run(50, 30, 5);
    chk("late.sw_width", n_sw_hi, 32);
    chk("late.done_t", done_t1, 37);

    // One extra request in RELEASE
    clr_pats(); req_pat[0] = 1'b1; req_pat[12] = 1'b1;
    sw_run(70, 3, 20);
    chk("b2b.n_rise", n_rise, 2);
    chk("b2b.n_done", n_done, 2);
    chk("b2b.rise2_t", rise_t2, 26);
    chk("b2b.done2_t", done_t2, 50);
    chk("b2b.sw_width", n_sw_hi, 16);

    // Three requests in RELEASE coalesce
    clr_pats(); req_pat[0] = 1'b1; req_pat[12] = 1'b1; req_pat[15] = 1'b1; req_pat[18] = 1'b1;
    sw_run(70, 3, 20);
    chk("coalesce.n_rise", n_rise, 2);
    chk("coalesce.n_done", n_done, 2);
    chk("coalesce.sw_width", n_sw_hi, 16);

    // Abort in ASSERT, then a fresh request proves IDLE
    clr_pats(); req_pat[0] = 1'b1; rst_pat[4] = 1'b1; rst_pat[5] = 1'b1; req_pat[20] = 1'b1;
    sw_run(45, 3, 5);
    chk("abort.sw_before", o_sw[4], 1);
    chk("abort.sw_after", o_sw[5], 0);
    chk("abort.busy_after", o_busy[5], 0);
    chk("abort.lk_after", o_lk[5], 0);
    chk("abort.n_rise", n_rise, 2);
    chk("abort.rise2_t", rise_t2, 21);
    chk("abort.sw_width", n_sw_hi, 12);
    chk("abort.n_done", n_done, 1);
    chk("abort.done_t", done_t1, 30);

    // Abort in RELEASE drops the pending request
    clr_pats(); req_pat[0] = 1'b1; req_pat[12] = 1'b1; rst_pat[15] = 1'b1;
    sw_run(60, 3, 20);
    chk("abort_rel.busy_before", o_busy[15], 1);
    chk("abort_rel.busy_after", o_busy[16], 0);
    chk("abort_rel.n_rise", n_rise, 1);
    chk("abort_rel.n_done", n_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
